sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Round-robin arbiter sharing the single-port, active-low-strobed SRAM macro between NPORTS requesters (core instruction fetch, core data port, debug/loader port). Grants at most one access per cycle, drives the SRAM strobes directly and routes the one-cycle-latency read data back to the winning port. Sits between the core's memory ports and the `sram_*` pins of `top`.

## Interface
- `NPORTS`, 2: number of requester ports (2..4).
- `AW`, 32: byte address width passed to the SRAM.
- `HCLK`  in  1  single clock; all state on rising edge.
- `HRESETn`  in  1  asynchronous, active-low reset.
- `req`  in  [NPORTS]  access request per port.
- `we`  in  [NPORTS]  1 = write, 0 = read.
- `be`  in  [NPORTS][4]  active-high byte enables (writes only).
- `addr`  in  [NPORTS][AW]  byte address; passed through unmodified.
- `wdata`  in  [NPORTS][32]  write data.
- `gnt`  out  [NPORTS]  one-hot; access issued to SRAM this cycle.
- `rvalid`  out  [NPORTS]  one-hot; read data valid on `rdata` this cycle.
- `rdata`  out  32  shared read data (copy of `sram_dout`).
- `sram_cen`  out  1  chip enable, active low.
- `sram_wen`  out  1  write enable, active low.
- `sram_ben`  out  4  byte enables, active low.
- `sram_addr`  out  AW  address.
- `sram_din`  out  32  write data.
- `sram_dout`  in  32  read data, registered by macro, valid the cycle after access.
- `lock`  in  [NPORTS]  only with `SRAM_ARB_LOCK_EN`; see Configuration.

## Operation
- Requester asserts `req` with `we/be/addr/wdata` stable and holds until sampled `gnt`; dropping `req` before `gnt` is allowed (request withdrawn).
- `gnt` is combinational from `req` and registered priority pointer `rr_ptr`; winner = first requesting port at or after `rr_ptr`, modulo NPORTS.
- On grant to port k: `rr_ptr <= (k+1) mod NPORTS`. No grant: `rr_ptr` holds.
- SRAM drive on grant: `sram_cen=0`, `sram_wen=~we[k]`, `sram_ben=we[k] ? ~be[k] : 4'h0`, `sram_addr=addr[k]`, `sram_din=wdata[k]`.
- Idle drive: `sram_cen=1`, `sram_wen=1`, `sram_ben=4'hF`, `sram_addr=0`, `sram_din=0`.
- Write with `be=0` is still granted (SRAM cycle with all bytes masked).
- Registered `rd_owner` (one-hot) and `rd_pend` capture a granted read; next cycle `rvalid[rd_owner]=1`, `rdata=sram_dout`. Writes never produce `rvalid`.
- Back-to-back grants each cycle supported: read in cycle N returns in N+1 while a new access issues in N+1.
- `rdata` equals `sram_dout` unconditionally; meaningful only with `rvalid`.

## Timing
- Grant latency: 0 cycles when uncontended; worst case NPORTS-1 cycles of wait with all ports requesting continuously.
- Read latency: `rvalid` exactly 1 cycle after `gnt`.
- Throughput: one access per cycle.
- Reset (async assert): `rr_ptr=0`, `rd_pend=0`, `rd_owner=0`, lock owner cleared. While `HRESETn=0`: `gnt=0`, `rvalid=0`, SRAM pins at idle values.
- Reset asserted the cycle after a read grant: `rvalid` is not produced; read is dropped.
- Simultaneous `req` on all ports after reset: port 0 wins first, then 1, 2, …

## Configuration
- `SRAM_ARB_LOCK_EN` defined: `lock` port present. A port granted with `lock[k]=1` becomes lock owner; while owned, only port k can be granted, `rr_ptr` frozen; ownership released on the first grant to k with `lock[k]=0`, or if `req[k]` drops with `lock[k]=0`. Used for read-modify-write sequences.
- Undefined: no `lock` port, no lock owner register; pure round-robin.

## Test plan
- Reset: hold `HRESETn=0` with all `req=1` -> `gnt=0`, `sram_cen=1`, `sram_ben=4'hF`, `rvalid=0`.
- Single port 1 write `addr=0x10, wdata=0xDEADBEEF, be=4'b0011`, then read `0x10` -> `sram_ben=4'b1100` on write; `rvalid[1]` one cycle after read grant, `rdata=0x0000BEEF` over a zero-initialised SRAM model.
- NPORTS=2, both ports request reads continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; each `rvalid` follows its `gnt` by one cycle with correct port's data.
- Port 0 requests every cycle, port 1 requests once at cycle 3 -> port 1 granted no later than cycle 4; no port waits more than NPORTS-1 cycles.
- Reset pulsed one cycle after a read grant -> no `rvalid`, `rr_ptr` back to 0, next simultaneous request granted to port 0.
- With `SRAM_ARB_LOCK_EN`: port 0 read with `lock=1`, port 1 requesting -> port 1 blocked until port 0 write with `lock=0` granted; port 1 granted the following cycle.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of the SRAM port arbiter.
// Lock signal exists only when SRAM_ARB_LOCK_EN is defined.
interface sram_port_arbiter_if #(
  parameter int NPORTS = 2,
  parameter int AW     = 32
);
  logic [NPORTS-1:0]          req;
  logic [NPORTS-1:0]          we;
  logic [NPORTS-1:0][3:0]     be;
  logic [NPORTS-1:0][AW-1:0]  addr;
  logic [NPORTS-1:0][31:0]    wdata;
  logic [NPORTS-1:0]          gnt;
  logic [NPORTS-1:0]          rvalid;
  logic [31:0]                rdata;
`ifdef SRAM_ARB_LOCK_EN
  logic [NPORTS-1:0]          lock;

  modport master (
    output req, we, be, addr, wdata, lock,
    input  gnt, rvalid, rdata
  );
  modport slave (
    input  req, we, be, addr, wdata, lock,
    output gnt, rvalid, rdata
  );
`else
  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );
  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
`endif
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter for the single-port SRAM macro.
// Optional bus locking: define SRAM_ARB_LOCK_EN.
module sram_port_arbiter #(
  parameter int NPORTS = 2,
  parameter int AW     = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  sram_port_arbiter_if.slave bus,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [3:0]    sram_ben,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_din,
  input  logic [31:0]   sram_dout
);

  localparam int PW = $clog2(NPORTS);

  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NPORTS-1:0] rd_owner_q, rd_owner_d;
  logic              rd_pend_q, rd_pend_d;
  logic [NPORTS-1:0] elig;
  logic [PW-1:0]     win;
  logic [PW-1:0]     idx;
  logic              hit;
  logic              frz;
`ifdef SRAM_ARB_LOCK_EN
  logic [NPORTS-1:0] lk_q, lk_d;
`endif

  // Ports allowed to compete this cycle
  always_comb begin
    elig = HRESETn ? bus.req : '0;
    frz  = 1'b0;
`ifdef SRAM_ARB_LOCK_EN
    if (|lk_q) begin
      elig = elig & lk_q;
      frz  = 1'b1;
    end
`endif
  end

  // First eligible port at or after the pointer wins
  always_comb begin
    hit     = 1'b0;
    win     = '0;
    idx     = '0;
    bus.gnt = '0;
    for (int i = 0; i < NPORTS; i++) begin
      idx = PW'((int'(rr_ptr_q) + i) % NPORTS);
      if (!hit && elig[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
    if (hit) bus.gnt[win] = 1'b1;
  end

  // SRAM pins follow the winner, idle otherwise
  always_comb begin
    sram_cen  = 1'b1;
    sram_wen  = 1'b1;
    sram_ben  = 4'hF;
    sram_addr = '0;
    sram_din  = '0;
    if (hit) begin
      sram_cen  = 1'b0;
      sram_wen  = ~bus.we[win];
      sram_ben  = bus.we[win] ? ~bus.be[win] : 4'h0;
      sram_addr = bus.addr[win];
      sram_din  = bus.wdata[win];
    end
  end

  // Next pointer, read tracking and lock ownership
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rd_pend_d  = hit & ~bus.we[win];
    rd_owner_d = rd_pend_d ? bus.gnt : '0;
    if (hit && !frz) begin
      if (int'(win) == NPORTS - 1) rr_ptr_d = '0;
      else                         rr_ptr_d = win + 1'b1;
    end
`ifdef SRAM_ARB_LOCK_EN
    lk_d = lk_q;
    if (|lk_q) begin
      if (|(lk_q & ~bus.lock & (bus.gnt | ~bus.req)))
        lk_d = '0;
    end else if (|(bus.gnt & bus.lock)) begin
      lk_d = bus.gnt;
    end
`endif
  end

  // State registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rr_ptr_q   <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= '0;
`ifdef SRAM_ARB_LOCK_EN
      lk_q       <= '0;
`endif
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
`ifdef SRAM_ARB_LOCK_EN
      lk_q       <= lk_d;
`endif
    end
  end

  assign bus.rvalid = rd_owner_q & {NPORTS{rd_pend_q}};
  assign bus.rdata  = sram_dout;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter with an SRAM model
// and a read-return scoreboard.
module tb_sram_port_arbiter;

  localparam int NP = 2;
  localparam int AW = 32;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          sram_cen, sram_wen;
  logic [3:0]    sram_ben;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_din;
  logic [31:0]   sram_dout = '0;

  sram_port_arbiter_if #(.NPORTS(NP), .AW(AW)) bus();

  sram_port_arbiter #(.NPORTS(NP), .AW(AW)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .bus       (bus),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_ben  (sram_ben),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  always #5 HCLK = ~HCLK;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_n  = 0;

  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic [NP-1:0] ev;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] w;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Zero-initialised SRAM, one-cycle registered read
  always @(posedge HCLK) begin
    cyc_n++;
    if (!sram_cen) begin
      w = mem.exists(sram_addr) ? mem[sram_addr] : 32'h0;
      if (!sram_wen) begin
        for (int b = 0; b < 4; b++)
          if (!sram_ben[b]) w[b*8 +: 8] = sram_din[b*8 +: 8];
        mem[sram_addr] = w;
      end else begin
        sram_dout <= w;
      end
    end
  end

  // Read returns checked against the scoreboard
  always @(negedge HCLK) begin
    ev = '0;
    if (q.size() > 0 && q[0].cyc == cyc_n) begin
      e = q.pop_front();
      ev[e.port] = 1'b1;
      chk("rdata", {32'h0, bus.rdata}, {32'h0, e.data});
    end
    chk("rvalid", 64'(bus.rvalid), 64'(ev));
  end

  task automatic drv(int p, logic r, logic wr,
                     logic [3:0] b, logic [31:0] a,
                     logic [31:0] d);
    bus.req[p]   = r;
    bus.we[p]    = wr;
    bus.be[p]    = b;
    bus.addr[p]  = a;
    bus.wdata[p] = d;
  endtask

  task automatic gchk(logic [NP-1:0] eg, int rp,
                      logic [31:0] rd);
    chk("gnt", 64'(bus.gnt), 64'(eg));
    if (rp >= 0)
      q.push_back('{cyc: cyc_n + 1, port: rp, data: rd});
  endtask

  task automatic nxt();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    bus.req   = '0;
    bus.we    = '0;
    bus.be    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
`ifdef SRAM_ARB_LOCK_EN
    bus.lock  = '0;
`endif
    // reset with everyone requesting
    bus.req = '1;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_gnt", 64'(bus.gnt), 64'h0);
    chk("rst_cen", 64'(sram_cen), 64'h1);
    chk("rst_wen", 64'(sram_wen), 64'h1);
    chk("rst_ben", 64'(sram_ben), 64'hF);
    chk("rst_addr", 64'(sram_addr), 64'h0);
    #1;
    bus.req = '0;
    HRESETn = 1'b1;
    nxt();

    // port 1 partial write then readback
    drv(1, 1, 1, 4'b0011, 32'h10, 32'hDEADBEEF);
    @(negedge HCLK);
    gchk(2'b10, -1, 0);
    chk("wr_ben", 64'(sram_ben), 64'hC);
    chk("wr_wen", 64'(sram_wen), 64'h0);
    chk("wr_cen", 64'(sram_cen), 64'h0);
    chk("wr_addr", 64'(sram_addr), 64'h10);
    chk("wr_din", 64'(sram_din), 64'hDEADBEEF);
    nxt();
    drv(1, 1, 0, 4'h0, 32'h10, 32'h0);
    @(negedge HCLK);
    gchk(2'b10, 1, 32'h0000BEEF);
    chk("rd_ben", 64'(sram_ben), 64'h0);
    chk("rd_wen", 64'(sram_wen), 64'h1);
    nxt();
    drv(1, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge HCLK);
    gchk(2'b00, -1, 0);
    chk("idle_cen", 64'(sram_cen), 64'h1);
    nxt();

    // preload two words
    drv(0, 1, 1, 4'hF, 32'h20, 32'hA0A0A0A0);
    @(negedge HCLK);
    gchk(2'b01, -1, 0);
    nxt();
    drv(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drv(1, 1, 1, 4'hF, 32'h24, 32'h1B1B1B1B);
    @(negedge HCLK);
    gchk(2'b10, -1, 0);
    nxt();

    // both ports reading: strict alternation
    drv(0, 1, 0, 4'h0, 32'h20, 32'h0);
    drv(1, 1, 0, 4'h0, 32'h24, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK);
      if (i % 2 == 0) gchk(2'b01, 0, 32'hA0A0A0A0);
      else            gchk(2'b10, 1, 32'h1B1B1B1B);
      nxt();
    end
    drv(1, 0, 0, 4'h0, 32'h0, 32'h0);

    // port 0 continuous, port 1 joins at cycle 3
    for (int i = 0; i < 5; i++) begin
      if (i == 3) drv(1, 1, 0, 4'h0, 32'h24, 32'h0);
      else        drv(1, 0, 0, 4'h0, 32'h0, 32'h0);
      @(negedge HCLK);
      if (i == 3) gchk(2'b10, 1, 32'h1B1B1B1B);
      else        gchk(2'b01, 0, 32'hA0A0A0A0);
      nxt();
    end
    drv(1, 0, 0, 4'h0, 32'h0, 32'h0);

    // write with no byte enables is still an SRAM cycle
    drv(0, 1, 1, 4'h0, 32'h20, 32'hFFFFFFFF);
    @(negedge HCLK);
    gchk(2'b01, -1, 0);
    chk("be0_ben", 64'(sram_ben), 64'hF);
    chk("be0_cen", 64'(sram_cen), 64'h0);
    nxt();
    drv(0, 1, 0, 4'h0, 32'h20, 32'h0);
    @(negedge HCLK);
    gchk(2'b01, 0, 32'hA0A0A0A0);
    nxt();

    // reset right after a read grant drops the read
    @(negedge HCLK);
    gchk(2'b01, -1, 0);
    nxt();
    HRESETn = 1'b0;
    drv(0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge HCLK);
    chk("rst2_gnt", 64'(bus.gnt), 64'h0);
    chk("rst2_cen", 64'(sram_cen), 64'h1);
    nxt();
    HRESETn = 1'b1;
    drv(0, 1, 0, 4'h0, 32'h20, 32'h0);
    drv(1, 1, 0, 4'h0, 32'h24, 32'h0);
    @(negedge HCLK);
    gchk(2'b01, 0, 32'hA0A0A0A0);
    nxt();
    drv(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drv(1, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge HCLK);
    gchk(2'b00, -1, 0);
    nxt();

`ifdef SRAM_ARB_LOCK_EN
    // locked read-modify-write by port 0
    drv(1, 1, 0, 4'h0, 32'h24, 32'h0);
    @(negedge HCLK);
    gchk(2'b10, 1, 32'h1B1B1B1B);
    nxt();
    drv(0, 1, 0, 4'h0, 32'h20, 32'h0);
    bus.lock[0] = 1'b1;
    @(negedge HCLK);
    gchk(2'b01, 0, 32'hA0A0A0A0);
    nxt();
    drv(0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge HCLK);
    gchk(2'b00, -1, 0);
    nxt();
    drv(0, 1, 1, 4'hF, 32'h28, 32'h12345678);
    bus.lock[0] = 1'b0;
    @(negedge HCLK);
    gchk(2'b01, -1, 0);
    nxt();
    drv(0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge HCLK);
    gchk(2'b10, 1, 32'h1B1B1B1B);
    nxt();
    drv(1, 0, 0, 4'h0, 32'h0, 32'h0);
`endif

    repeat (3) nxt();
    chk("drain", 64'(q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
